seven_seg_scan_driver: RTL and testbench

Parametrised, time-multiplexed hex display driver for DIGITS seven-segment digits. It latches a packed nibble vector into a shadow register and scans one digit per refresh slot. For each slot it drives a one-hot digit enable and the decoded segment pattern. Optional leading-zero blanking and a frame-complete pulse are included. It sits after the ALU/result path and replaces the single-digit combinational decoder.

---
 rtl/seven_seg_scan_driver.sv | 122 ++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_driver.sv
// rtl/seven_seg_scan_driver.sv - time-multiplexed hex display driver for DIGITS seven-segment digits
// Shadow-latched value, prescaled digit scan, registered one-hot anode/segment outputs.
module seven_seg_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 4,
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic [4*DIGITS-1:0]   value,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic [IW-1:0]         digit_idx,
  output logic                  frame_tick
);

  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                wrap_q, wrap_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [IW-1:0]       digit_idx_q, digit_idx_d;
  logic                frame_tick_q, frame_tick_d;

  logic [4*DIGITS-1:0] shifted;
  logic [3:0]          nibble;
  logic                lz_blank;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  always_comb begin
    shadow_d = load ? value : shadow_q;
    presc_d  = presc_q;
    idx_d    = idx_q;
    wrap_d   = 1'b0;
    if (enable) begin
      if (presc_q == PW'(REFRESH_DIV - 1)) begin
        presc_d = '0;
        if (idx_q == IW'(DIGITS - 1)) begin
          idx_d  = '0;
          wrap_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // Shifting the shadow down by the digit index exposes the current nibble and,
  // in the same word, every higher nibble for the leading-zero test.
  always_comb begin
    shifted  = shadow_q >> {idx_q, 2'b00};
    nibble   = shifted[3:0];
    lz_blank = blank_lz && (idx_q != '0) && (shifted == '0);

    digit_idx_d  = idx_q;
    an_d         = '0;
    seg_d        = '0;
    frame_tick_d = 1'b0;
    if (enable) begin
      an_d         = DIGITS'(1) << idx_q;
      seg_d        = lz_blank ? 7'b0000000 : hex_to_seg(nibble);
      frame_tick_d = wrap_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q     <= '0;
      presc_q      <= '0;
      idx_q        <= '0;
      wrap_q       <= 1'b0;
      seg_q        <= '0;
      an_q         <= '0;
      digit_idx_q  <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      wrap_q       <= wrap_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      digit_idx_q  <= digit_idx_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign digit_idx  = digit_idx_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb/tb_seven_seg_scan_driver.sv - table-driven bench for seven_seg_scan_driver
// Instance A: DIGITS=4, REFRESH_DIV=4. Instance B: DIGITS=2, REFRESH_DIV=1.
module tb_seven_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_a = 1'b0, ld_a = 1'b0, blz_a = 1'b0;
  logic [15:0] val_a = '0;
  logic [6:0]  seg_a;
  logic [3:0]  an_a;
  logic [1:0]  idx_a;
  logic        tick_a;
  logic        en_b = 1'b0, ld_b = 1'b0, blz_b = 1'b0;
  logic [7:0]  val_b = '0;
  logic [6:0]  seg_b;
  logic [1:0]  an_b;
  logic [0:0]  idx_b;
  logic        tick_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(.DIGITS(4), .REFRESH_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .enable(en_a), .load(ld_a), .blank_lz(blz_a),
    .value(val_a), .seg(seg_a), .an(an_a), .digit_idx(idx_a), .frame_tick(tick_a)
  );

  seven_seg_scan_driver #(.DIGITS(2), .REFRESH_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .enable(en_b), .load(ld_b), .blank_lz(blz_b),
    .value(val_b), .seg(seg_b), .an(an_b), .digit_idx(idx_b), .frame_tick(tick_b)
  );

  typedef struct {
    logic        en;
    logic        ld;
    logic        blz;
    logic [15:0] val;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [1:0]  idx;
    logic        tick;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic ld, input logic blz, input logic [15:0] val,
                     input logic [3:0] an, input logic [6:0] seg, input logic [1:0] idx,
                     input logic tick);
    vec_t v;
    v.en = en; v.ld = ld; v.blz = blz; v.val = val;
    v.an = an; v.seg = seg; v.idx = idx; v.tick = tick;
    tbl.push_back(v);
  endtask

  // k-th enabled edge after a fresh start shows digit ((k-1)/4)%4; tick on k=17,33,...
  task automatic scan_fill(input logic [15:0] val, input logic blz,
                           input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3, input int n);
    logic [6:0] segs [4];
    segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
    for (int k = 1; k <= n; k++) begin
      int d;
      d = ((k - 1) / 4) % 4;
      add(1'b1, 1'b0, blz, val, 4'(1 << d), segs[d], 2'(d), (k > 1) && ((k - 1) % 16 == 0));
    end
  endtask

  task automatic run_tbl(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      en_a = tbl[i].en; ld_a = tbl[i].ld; blz_a = tbl[i].blz; val_a = tbl[i].val;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s[%0d].an", name, i), 32'(an_a), 32'(tbl[i].an));
      check($sformatf("%s[%0d].seg", name, i), 32'(seg_a), 32'(tbl[i].seg));
      check($sformatf("%s[%0d].idx", name, i), 32'(idx_a), 32'(tbl[i].idx));
      check($sformatf("%s[%0d].tick", name, i), 32'(tick_a), 32'(tbl[i].tick));
    end
    tbl.delete();
    ld_a = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    en_a = 1'b0; ld_a = 1'b0; en_b = 1'b0; ld_b = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101;
  localparam logic [6:0] S4 = 7'b0110011, S7 = 7'b1110000, SA = 7'b1110111;
  localparam logic [6:0] SF = 7'b1000111, SC = 7'b1001110, S3 = 7'b1111001;

  initial begin
    #1 rst = 1'b1;
    #1;
    check("reset.an", 32'(an_a), 32'h0);
    check("reset.seg", 32'(seg_a), 32'h0);
    check("reset.idx", 32'(idx_a), 32'h0);
    check("reset.tick", 32'(tick_a), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Full scan of 12A4, two frames.
    reset_dut();
    add(1'b0, 1'b1, 1'b0, 16'h12A4, 4'b0000, 7'b0, 2'd0, 1'b0);
    scan_fill(16'h12A4, 1'b0, S4, SA, S2, S1, 33);
    run_tbl("scan");

    // Async reset between edges while frame_tick is high.
    #2 rst = 1'b1;
    #1;
    check("async.an", 32'(an_a), 32'h0);
    check("async.seg", 32'(seg_a), 32'h0);
    check("async.idx", 32'(idx_a), 32'h0);
    check("async.tick", 32'(tick_a), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    scan_fill(16'h12A4, 1'b0, S0, S0, S0, S0, 5);
    run_tbl("restart");

    // Leading-zero blanking on and off.
    reset_dut();
    add(1'b0, 1'b1, 1'b1, 16'h0070, 4'b0000, 7'b0, 2'd0, 1'b0);
    scan_fill(16'h0070, 1'b1, S0, S7, 7'b0, 7'b0, 16);
    run_tbl("blank_on");
    reset_dut();
    add(1'b0, 1'b1, 1'b0, 16'h0070, 4'b0000, 7'b0, 2'd0, 1'b0);
    scan_fill(16'h0070, 1'b0, S0, S7, S0, S0, 16);
    run_tbl("blank_off");

    // Pause on digit 2 with prescaler at 2, then resume.
    reset_dut();
    add(1'b0, 1'b1, 1'b0, 16'h12A4, 4'b0000, 7'b0, 2'd0, 1'b0);
    scan_fill(16'h12A4, 1'b0, S4, SA, S2, S1, 10);
    add(1'b0, 1'b0, 1'b0, 16'h12A4, 4'b0000, 7'b0, 2'd2, 1'b0);
    add(1'b0, 1'b0, 1'b0, 16'h12A4, 4'b0000, 7'b0, 2'd2, 1'b0);
    add(1'b1, 1'b0, 1'b0, 16'h12A4, 4'b0100, S2, 2'd2, 1'b0);
    add(1'b1, 1'b0, 1'b0, 16'h12A4, 4'b0100, S2, 2'd2, 1'b0);
    add(1'b1, 1'b0, 1'b0, 16'h12A4, 4'b1000, S1, 2'd3, 1'b0);
    run_tbl("pause");

    // Mid-scan load of FFFF on digit 2; later live value change without load.
    reset_dut();
    add(1'b0, 1'b1, 1'b0, 16'h12A4, 4'b0000, 7'b0, 2'd0, 1'b0);
    scan_fill(16'h12A4, 1'b0, S4, SA, S2, S1, 9);
    add(1'b1, 1'b1, 1'b0, 16'hFFFF, 4'b0100, S2, 2'd2, 1'b0);
    add(1'b1, 1'b0, 1'b0, 16'hFFFF, 4'b0100, SF, 2'd2, 1'b0);
    add(1'b1, 1'b0, 1'b0, 16'h0000, 4'b0100, SF, 2'd2, 1'b0);
    add(1'b1, 1'b0, 1'b0, 16'h0000, 4'b1000, SF, 2'd3, 1'b0);
    run_tbl("midload");

    // Minimal instance: two digits, one cycle per slot.
    reset_dut();
    val_b = 8'h3C; ld_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ld_b = 1'b0; en_b = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      logic [1:0] e_an;
      logic [6:0] e_seg;
      e_an  = (k % 2 == 1) ? 2'b01 : 2'b10;
      e_seg = (k % 2 == 1) ? SC : S3;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("min[%0d].an", k), 32'(an_b), 32'(e_an));
      check($sformatf("min[%0d].seg", k), 32'(seg_b), 32'(e_seg));
      check($sformatf("min[%0d].idx", k), 32'(idx_b), 32'((k % 2 == 1) ? 0 : 1));
      check($sformatf("min[%0d].tick", k), 32'(tick_b), 32'((k > 1) && (k % 2 == 1)));
    end
    en_b = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
